// File: rtl/safecrack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : safecrack_pkg
//  Purpose  : Shared types and helpers for the parametrised safe cracker.
//             state_t is one-hot so an illegal pattern is easy to detect
//             and can be sent back to IDLE.
//  Revision : 1.0 - initial release
// ============================================================================
package safecrack_pkg;

    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        OPEN    = 5'b00010,
        ERR     = 5'b00100,
        LOCK    = 5'b01000,
        PROGRAM = 5'b10000
    } state_t;

    // Number of clock cycles in s seconds at hz.
    function automatic int unsigned secs_to_ticks(input int unsigned hz, input int unsigned s);
        return hz * s;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/safecrack_btn_edge.sv
`default_nettype none
// ============================================================================
//  Module   : safecrack_btn_edge
//  Purpose  : Conditions the raw active-low buttons. Each button is
//             inverted, synchronised through two flops, and a press edge is
//             produced on the first synchronised cycle a button is down. A
//             held button therefore produces exactly one edge.
//  Ports    : clk, rstn      - clock, asynchronous active-low reset
//             btn[N-1:0]     - raw buttons, active-low, asynchronous
//             btn_edge[N-1:0]- one-cycle press pulses
//             onehot         - exactly one bit of btn_edge is set
//  Revision : 1.0 - initial release
// ============================================================================
module safecrack_btn_edge #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] btn,
    output logic [N-1:0] btn_edge,
    output logic         onehot
);

    logic [N-1:0] sync1;
    logic [N-1:0] sync2;
    logic [N-1:0] prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= ~btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign btn_edge = sync2 & ~prev;
    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign onehot   = (btn_edge != '0) && ((btn_edge & (btn_edge - 1'b1)) == '0);

endmodule
`default_nettype wire

// File: rtl/safecrack_param.sv
`default_nettype none
// ============================================================================
//  Module   : safecrack_param
//  Purpose  : Parametrised combination lock. A CODE_LEN-digit code entered
//             on NUM_BTN buttons opens the safe; the code can be rewritten
//             while open; MAX_FAIL consecutive failures force a lockout.
//  Ports    : clk, rstn        - clock, asynchronous active-low reset
//             btn              - raw active-low buttons
//             prog_en          - request programming (honoured in OPEN)
//             leds_progress    - thermometer of accepted digits
//             led_open/err/lock/prog - state indicators
//             fail_cnt         - consecutive failures (saturating)
//  Revision : 1.0 - initial release
// ============================================================================
module safecrack_param
    import safecrack_pkg::*;
#(
    parameter int          NUM_BTN  = 4,
    parameter int          CODE_LEN = 4,
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned OPEN_S   = 5,
    parameter int unsigned ERR_S    = 3,
    parameter int unsigned LOCK_S   = 30,
    parameter int unsigned PROG_S   = 10,
    parameter int          MAX_FAIL = 3,
    parameter logic [CODE_LEN*$clog2(NUM_BTN)-1:0] DEFAULT_CODE = {2'd3, 2'd2, 2'd1, 2'd0}
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_BTN-1:0]            btn,
    input  logic                          prog_en,
    output logic [CODE_LEN-1:0]           leds_progress,
    output logic                          led_open,
    output logic                          led_err,
    output logic                          led_lock,
    output logic                          led_prog,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int          DW        = $clog2(NUM_BTN);
    localparam int          IW        = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int          FW        = $clog2(MAX_FAIL + 1);
    localparam int unsigned MAX_S     = max2(max2(OPEN_S, LOCK_S), max2(PROG_S, ERR_S));
    localparam int unsigned MAX_TICKS = secs_to_ticks(CLK_HZ, MAX_S);
    localparam int          TW        = $clog2(MAX_TICKS + 1);

    // Timers load ticks-1 so the dwell, including the zero cycle, is ticks.
    localparam logic [TW-1:0] OPEN_LD = TW'(secs_to_ticks(CLK_HZ, OPEN_S) - 1);
    localparam logic [TW-1:0] ERR_LD  = TW'(secs_to_ticks(CLK_HZ, ERR_S) - 1);
    localparam logic [TW-1:0] LOCK_LD = TW'(secs_to_ticks(CLK_HZ, LOCK_S) - 1);
    localparam logic [TW-1:0] PROG_LD = TW'(secs_to_ticks(CLK_HZ, PROG_S) - 1);
    localparam logic [IW-1:0] LAST    = IW'(CODE_LEN - 1);

    logic [NUM_BTN-1:0]     btn_edge;
    logic                   onehot;
    logic                   evt;
    logic [DW-1:0]          digit;
    logic [DW-1:0]          exp_digit;

    state_t                 state,    state_n;
    logic [TW-1:0]          timer,    timer_n;
    logic [IW-1:0]          idx,      idx_n;
    logic [IW-1:0]          pidx,     pidx_n;
    logic [FW-1:0]          fail_n;
    logic [CODE_LEN*DW-1:0] code,     code_n;
    logic [CODE_LEN*DW-1:0] shadow,   shadow_n;

    safecrack_btn_edge #(.N(NUM_BTN)) u_btn_edge (
        .clk      (clk),
        .rstn     (rstn),
        .btn      (btn),
        .btn_edge (btn_edge),
        .onehot   (onehot)
    );

    assign evt = (btn_edge != '0);

    // Index of the pressed button; only meaningful when onehot is set.
    always_comb begin
        digit = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (btn_edge[i]) digit = DW'(i);
        end
    end

    // Digit the lock expects next.
    always_comb begin
        exp_digit = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (IW'(i) == idx) exp_digit = code[i*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            timer    <= '0;
            idx      <= '0;
            pidx     <= '0;
            fail_cnt <= '0;
            code     <= DEFAULT_CODE;
            shadow   <= '0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            idx      <= idx_n;
            pidx     <= pidx_n;
            fail_cnt <= fail_n;
            code     <= code_n;
            shadow   <= shadow_n;
        end
    end

    always_comb begin
        state_n  = state;
        timer_n  = (timer != '0) ? timer - 1'b1 : '0;
        idx_n    = idx;
        pidx_n   = pidx;
        fail_n   = fail_cnt;
        code_n   = code;
        shadow_n = shadow;

        leds_progress = '0;
        led_open      = 1'b0;
        led_err       = 1'b0;
        led_lock      = 1'b0;
        led_prog      = 1'b0;

        case (state)
            IDLE: begin
                for (int i = 0; i < CODE_LEN; i++) begin
                    leds_progress[i] = (IW'(i) < idx);
                end
                if (evt) begin
                    if (onehot && (digit == exp_digit)) begin
                        if (idx == LAST) begin
                            state_n = OPEN;
                            timer_n = OPEN_LD;
                            fail_n  = '0;
                            idx_n   = '0;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end else begin
                        idx_n = '0;
                        if (fail_cnt >= FW'(MAX_FAIL - 1)) begin
                            state_n = LOCK;
                            timer_n = LOCK_LD;
                            fail_n  = FW'(MAX_FAIL);
                        end else begin
                            state_n = ERR;
                            timer_n = ERR_LD;
                            fail_n  = fail_cnt + 1'b1;
                        end
                    end
                end
            end
            OPEN: begin
                leds_progress = '1;
                led_open      = 1'b1;
                if (prog_en) begin
                    state_n = PROGRAM;
                    pidx_n  = '0;
                    timer_n = PROG_LD;
                end else if (timer == '0) begin
                    state_n = IDLE;
                end
            end
            ERR: begin
                led_err = 1'b1;
                if (timer == '0) state_n = IDLE;
            end
            LOCK: begin
                led_lock = 1'b1;
                if (timer == '0) begin
                    state_n = IDLE;
                    fail_n  = '0;
                end
            end
            PROGRAM: begin
                led_prog = 1'b1;
                if (evt) begin
                    if (onehot) begin
                        for (int i = 0; i < CODE_LEN; i++) begin
                            if (IW'(i) == pidx) shadow_n[i*DW +: DW] = digit;
                        end
                        if (pidx == LAST) begin
                            // Commit includes the digit being written this cycle.
                            code_n  = shadow_n;
                            pidx_n  = '0;
                            state_n = IDLE;
                        end else begin
                            pidx_n  = pidx + 1'b1;
                            timer_n = PROG_LD;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end else if (timer == '0) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_safecrack_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_safecrack_param
//  Purpose  : Self-checking bench for safecrack_param at CLK_HZ=10.
//             Expected output vectors are queued as stimulus is applied and
//             compared whenever the DUT outputs change, together with how
//             long the previous output vector was held.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_safecrack_param;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] btn  = 4'hF;
    logic       prog_en = 1'b0;
    logic [3:0] leds_progress;
    logic       led_open, led_err, led_lock, led_prog;
    logic [1:0] fail_cnt;
    logic [9:0] outvec;

    always #5 clk = ~clk;

    safecrack_param #(.CLK_HZ(10)) u_dut (
        .clk           (clk),
        .rstn          (rstn),
        .btn           (btn),
        .prog_en       (prog_en),
        .leds_progress (leds_progress),
        .led_open      (led_open),
        .led_err       (led_err),
        .led_lock      (led_lock),
        .led_prog      (led_prog),
        .fail_cnt      (fail_cnt)
    );

    assign outvec = {leds_progress, led_open, led_err, led_lock, led_prog, fail_cnt};

    typedef struct {
        string      tag;
        logic [9:0] vec;
        int         dwell;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9:0] ov(input logic [3:0] l, input logic o, input logic e,
                                      input logic k, input logic p, input logic [1:0] f);
        return {l, o, e, k, p, f};
    endfunction

    task automatic push(input string tag, input logic [9:0] v, input int d);
        exp_t e;
        e.tag   = tag;
        e.vec   = v;
        e.dwell = d;
        sb.push_back(e);
    endtask

    // Output monitor: every change of the output vector consumes one record.
    initial begin
        logic [9:0] prev;
        int         dwell;
        exp_t       e;
        prev  = '0;
        dwell = 0;
        @(posedge rstn);
        forever begin
            @(negedge clk);
            if (outvec !== prev) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_change", {22'd0, outvec}, {22'd0, prev});
                end else begin
                    e = sb.pop_front();
                    check(e.tag, {22'd0, outvec}, {22'd0, e.vec});
                    if (e.dwell >= 0) check({e.tag, "_dwell"}, dwell, e.dwell);
                end
                prev  = outvec;
                dwell = 1;
            end else begin
                dwell++;
            end
        end
    end

    task automatic press(input int b, input int hold);
        @(negedge clk);
        btn[b] = 1'b0;
        repeat (hold) @(negedge clk);
        btn[b] = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic drain(input int budget, input string tag);
        int i;
        i = 0;
        while (sb.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        repeat (2) @(negedge clk);
        check(tag, sb.size(), 0);
        sb.delete();
    endtask

    task automatic wait_open(input string tag);
        int i;
        i = 0;
        while (!led_open && i < 200) begin
            @(negedge clk);
            i++;
        end
        check(tag, led_open, 1);
    endtask

    task automatic prog_pulse();
        prog_en = 1'b1;
        repeat (2) @(negedge clk);
        prog_en = 1'b0;
    endtask

    // Queue the progress and OPEN vectors for a full code, then enter it.
    task automatic open_seq(input int d0, input int d1, input int d2, input int d3,
                            input logic [1:0] f, input string tg);
        push({tg, "_p1"},   ov(4'b0001, 0, 0, 0, 0, f), -1);
        push({tg, "_p2"},   ov(4'b0011, 0, 0, 0, 0, f), -1);
        push({tg, "_p3"},   ov(4'b0111, 0, 0, 0, 0, f), -1);
        push({tg, "_open"}, ov(4'b1111, 1, 0, 0, 0, 0), -1);
        press(d0, 3);
        press(d1, 3);
        press(d2, 3);
        press(d3, 3);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("reset_out", outvec, 0);

        // Correct default code, open for exactly 50 cycles.
        open_seq(0, 1, 2, 3, 0, "t1");
        push("t1_close", ov(0, 0, 0, 0, 0, 0), 50);
        drain(200, "t1_drain");

        // Three wrong first digits: ERR, ERR, LOCK; presses ignored in LOCK.
        push("t3_err1",  ov(0, 0, 1, 0, 0, 1), -1);
        push("t3_idle1", ov(0, 0, 0, 0, 0, 1), 30);
        press(1, 3);
        drain(100, "t3_drain1");
        push("t3_err2",  ov(0, 0, 1, 0, 0, 2), -1);
        push("t3_idle2", ov(0, 0, 0, 0, 0, 2), 30);
        press(1, 3);
        drain(100, "t3_drain2");
        push("t3_lock",   ov(0, 0, 0, 1, 0, 3), -1);
        push("t3_unlock", ov(0, 0, 0, 0, 0, 0), 300);
        press(1, 3);
        press(0, 3);
        press(2, 3);
        drain(500, "t3_drain3");

        // Right first digit, wrong second.
        push("t2_p1",   ov(4'b0001, 0, 0, 0, 0, 0), -1);
        push("t2_err",  ov(0, 0, 1, 0, 0, 1), -1);
        push("t2_idle", ov(0, 0, 0, 0, 0, 1), 30);
        press(0, 3);
        press(2, 3);
        drain(100, "t2_drain");

        // Reprogram to 3,3,1,0.
        open_seq(0, 1, 2, 3, 1, "t4");
        push("t4_prog",   ov(0, 0, 0, 0, 1, 0), -1);
        push("t4_commit", ov(0, 0, 0, 0, 0, 0), -1);
        wait_open("t4_open_seen");
        prog_pulse();
        press(3, 3);
        press(3, 3);
        press(1, 3);
        press(0, 3);
        drain(100, "t4_drain1");
        push("t4_old_err",  ov(0, 0, 1, 0, 0, 1), -1);
        push("t4_old_idle", ov(0, 0, 0, 0, 0, 1), 30);
        press(0, 3);
        drain(100, "t4_drain2");
        open_seq(3, 3, 1, 0, 1, "t4n");
        push("t4n_close", ov(0, 0, 0, 0, 0, 0), 50);
        drain(200, "t4n_drain");

        // PROGRAM inactivity timeout after two digits; reload on each digit.
        open_seq(3, 3, 1, 0, 0, "t5a");
        push("t5a_prog", ov(0, 0, 0, 0, 1, 0), -1);
        push("t5a_tmo",  ov(0, 0, 0, 0, 0, 0), -1);
        wait_open("t5a_open_seen");
        prog_pulse();
        press(1, 3);
        press(2, 3);
        repeat (88) @(negedge clk);
        check("t5a_prog_held", led_prog, 1);
        drain(100, "t5a_drain");
        open_seq(3, 3, 1, 0, 0, "t5b");
        push("t5b_close", ov(0, 0, 0, 0, 0, 0), 50);
        drain(200, "t5b_drain");

        // Two buttons in the same cycle abort programming.
        open_seq(3, 3, 1, 0, 0, "t5c");
        push("t5c_prog",  ov(0, 0, 0, 0, 1, 0), -1);
        push("t5c_abort", ov(0, 0, 0, 0, 0, 0), -1);
        wait_open("t5c_open_seen");
        prog_pulse();
        @(negedge clk);
        btn = 4'b1100;
        repeat (3) @(negedge clk);
        btn = 4'hF;
        repeat (6) @(negedge clk);
        drain(50, "t5c_drain");
        open_seq(3, 3, 1, 0, 0, "t5d");
        push("t5d_close", ov(0, 0, 0, 0, 0, 0), 50);
        drain(200, "t5d_drain");

        // Reset in the middle of PROGRAM restores the default code.
        open_seq(3, 3, 1, 0, 0, "t6a");
        push("t6_prog", ov(0, 0, 0, 0, 1, 0), -1);
        push("t6_rst",  ov(0, 0, 0, 0, 0, 0), -1);
        wait_open("t6_open_seen");
        prog_pulse();
        press(2, 3);
        @(negedge clk);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_rst_out", outvec, 0);
        rstn = 1'b1;
        drain(10, "t6_rst_drain");

        // A button held for 20 cycles counts once, then default code opens.
        push("t6_p1",    ov(4'b0001, 0, 0, 0, 0, 0), -1);
        push("t6_p2",    ov(4'b0011, 0, 0, 0, 0, 0), -1);
        push("t6_p3",    ov(4'b0111, 0, 0, 0, 0, 0), -1);
        push("t6_open",  ov(4'b1111, 1, 0, 0, 0, 0), -1);
        push("t6_close", ov(0, 0, 0, 0, 0, 0), 50);
        press(0, 20);
        press(1, 3);
        press(2, 3);
        press(3, 3);
        drain(200, "t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
